// File: rtl/spi_boot_loader_ctrl.sv
// spi_boot_loader_ctrl
// Turns header-framed 32-bit words from the SPI deserializer into ICCM/DCCM
// write transactions and holds the core in reset until loading is complete
// and boot is enabled.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   rx_spi_inst_i/valid_i   received SPI word and its single-cycle strobe
//   en_i                    boot enable level, honoured only once loading is done
//   mem_req_o/addr_o/wdata_o/mem_gnt_i/mem_rvalid_i  crossbar write port
//   system_rst_no           core reset, active-low
//   load_busy_o             a segment is in progress
//   load_done_o             last segment complete
//   err_o                   sticky protocol error (FIFO overflow or bad header)
//   words_written_o         saturating count of completed writes
module spi_boot_loader_ctrl #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  ICCM_BASE  = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0]  DCCM_BASE  = 32'h1000_0000,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] rx_spi_inst_i,
  input  logic                  rx_spi_valid_i,
  input  logic                  en_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  output logic                  system_rst_no,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  err_o,
  output logic [15:0]           words_written_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  // S_REQ waits for a data word; S_ISSUE holds the request until granted.
  typedef enum logic [2:0] {
    S_HDR, S_REQ, S_ISSUE, S_RSP, S_DONE, S_RUN, S_ERR
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full;
  logic                  pop, push_ok, overflow;
  logic [DATA_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] seg_base;
  logic [15:0]           seg_len;
  logic [15:0]           idx;
  logic                  seg_last;
  logic                  rsp_early;

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    head       = fifo_mem[rd_ptr[PW-1:0]];
    pop        = !fifo_empty && ((state == S_HDR) || (state == S_REQ));
    // After boot (and once errored) incoming words are simply discarded.
    push_ok    = rx_spi_valid_i && (state != S_RUN) && (state != S_ERR) && (!fifo_full || pop);
    overflow   = rx_spi_valid_i && (state != S_RUN) && (state != S_ERR) && fifo_full && !pop;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= rx_spi_inst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_HDR;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mem_req_o       <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      system_rst_no   <= 1'b0;
      load_busy_o     <= 1'b0;
      load_done_o     <= 1'b0;
      err_o           <= 1'b0;
      words_written_o <= '0;
      seg_base        <= '0;
      seg_len         <= '0;
      idx             <= '0;
      seg_last        <= 1'b0;
      rsp_early       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      if (overflow) begin
        state       <= S_ERR;
        err_o       <= 1'b1;
        mem_req_o   <= 1'b0;
        load_busy_o <= 1'b0;
      end else begin
        case (state)
          S_HDR: if (!fifo_empty) begin
            if (head[29:16] != '0) begin
              state <= S_ERR;
              err_o <= 1'b1;
            end else if (head[15:0] == '0) begin
              if (head[31]) begin
                state       <= S_DONE;
                load_done_o <= 1'b1;
              end
            end else begin
              seg_last    <= head[31];
              seg_base    <= head[30] ? DCCM_BASE : ICCM_BASE;
              seg_len     <= head[15:0];
              idx         <= '0;
              load_busy_o <= 1'b1;
              state       <= S_REQ;
            end
          end
          S_REQ: if (!fifo_empty) begin
            mem_wdata_o <= head;
            mem_addr_o  <= seg_base + ADDR_WIDTH'({idx, 2'b00});
            mem_req_o   <= 1'b1;
            state       <= S_ISSUE;
          end
          S_ISSUE: if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            // A response arriving with the grant is remembered so RSP
            // completes after a single cycle.
            rsp_early <= mem_rvalid_i;
            state     <= S_RSP;
          end
          S_RSP: if (mem_rvalid_i || rsp_early) begin
            rsp_early <= 1'b0;
            idx       <= idx + 16'd1;
            if (words_written_o != 16'hFFFF) words_written_o <= words_written_o + 16'd1;
            if ((idx + 16'd1) == seg_len) begin
              load_busy_o <= 1'b0;
              if (seg_last) begin
                state       <= S_DONE;
                load_done_o <= 1'b1;
              end else begin
                state <= S_HDR;
              end
            end else begin
              state <= S_REQ;
            end
          end
          S_DONE: if (en_i) begin
            system_rst_no <= 1'b1;
            state         <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_boot_loader_ctrl.sv
module tb_spi_boot_loader_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] rx_spi_inst_i;
  logic        rx_spi_valid_i;
  logic        en_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic        system_rst_no;
  logic        load_busy_o;
  logic        load_done_o;
  logic        err_o;
  logic [15:0] words_written_o;

  spi_boot_loader_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .ICCM_BASE  (32'h0000_0000),
    .DCCM_BASE  (32'h1000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rx_spi_inst_i   (rx_spi_inst_i),
    .rx_spi_valid_i  (rx_spi_valid_i),
    .en_i            (en_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .system_rst_no   (system_rst_no),
    .load_busy_o     (load_busy_o),
    .load_done_o     (load_done_o),
    .err_o           (err_o),
    .words_written_o (words_written_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  req_cycles = 0;

  // crossbar model controls
  int  gnt_wait = 0;
  bit  coincide = 0;
  bit  stall    = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Crossbar: grants after gnt_wait request cycles, responds one cycle
  // after the grant or together with it when coincide is set.
  initial begin
    int  age = 0;
    bit  rsp_due = 0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = rsp_due;
      rsp_due      = 0;
      mem_gnt_i    = 1'b0;
      if (mem_req_o && !stall && !rst_i) begin
        if (age >= gnt_wait) begin
          mem_gnt_i = 1'b1;
          age = 0;
          if (coincide) mem_rvalid_i = 1'b1;
          else          rsp_due = 1;
        end else begin
          age++;
        end
      end else if (!mem_req_o) begin
        age = 0;
      end
    end
  end

  // Monitor: every accepted write is popped from the scoreboard and compared.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    wr_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (mem_req_o) req_cycles++;
      if (mem_req_o && prev_req && !prev_gnt) begin
        check("hold_addr", mem_addr_o, prev_addr);
        check("hold_data", mem_wdata_o, prev_data);
      end
      if (mem_req_o && mem_gnt_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h want none", mem_addr_o, mem_wdata_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr_o, e.addr);
          check("wr_data", mem_wdata_o, e.data);
        end
      end
      prev_req  = mem_req_o;
      prev_gnt  = mem_gnt_i;
      prev_addr = mem_addr_o;
      prev_data = mem_wdata_o;
    end
  end

  // All driving tasks are entered and left on a falling edge.
  task automatic send(input logic [31:0] w);
    rx_spi_valid_i = 1'b1;
    rx_spi_inst_i  = w;
    @(negedge clk_i);
    rx_spi_valid_i = 1'b0;
  endtask

  task automatic send_gap(input logic [31:0] w);
    send(w);
    repeat (8) @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    en_i  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'd0, mem_req_o},     32'd0);
    check({tag, "_addr"},  mem_addr_o,             32'd0);
    check({tag, "_wdata"}, mem_wdata_o,            32'd0);
    check({tag, "_rstn"},  {31'd0, system_rst_no}, 32'd0);
    check({tag, "_busy"},  {31'd0, load_busy_o},   32'd0);
    check({tag, "_done"},  {31'd0, load_done_o},   32'd0);
    check({tag, "_err"},   {31'd0, err_o},         32'd0);
    check({tag, "_words"}, {16'd0, words_written_o}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (load_done_o) begin
        seen = 1;
        break;
      end
      @(negedge clk_i);
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (mem_req_o) begin
        seen = 1;
        break;
      end
      @(negedge clk_i);
    end
    check({tag, "_req_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !load_busy_o) begin
        seen = 1;
        break;
      end
      @(negedge clk_i);
    end
    check({tag, "_drained"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int rc;
    rst_i          = 1'b1;
    en_i           = 1'b0;
    rx_spi_valid_i = 1'b0;
    rx_spi_inst_i  = '0;
    @(negedge clk_i);
    do_reset();
    check_reset("reset");

    // Single ICCM segment, last
    expect_wr(32'h0, 32'hA1);
    expect_wr(32'h4, 32'hB2);
    expect_wr(32'h8, 32'hC3);
    send_gap(32'h8000_0003);
    send_gap(32'hA1);
    send_gap(32'hB2);
    send_gap(32'hC3);
    wait_done("t1");
    check("t1_words", {16'd0, words_written_o}, 32'd3);
    check("t1_qempty", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk_i);
    check("t1_rstn_before_en", {31'd0, system_rst_no}, 32'd0);
    en_i = 1'b1;
    @(negedge clk_i);
    check("t1_rstn_after_en", {31'd0, system_rst_no}, 32'd1);
    send_gap(32'h1234_5678);
    check("t1_run_no_err", {31'd0, err_o}, 32'd0);
    check("t1_run_rstn", {31'd0, system_rst_no}, 32'd1);

    // Two segments, slow grant
    do_reset();
    gnt_wait = 2;
    expect_wr(32'h0, 32'h1111_1111);
    expect_wr(32'h4, 32'h2222_2222);
    expect_wr(32'h1000_0000, 32'h5A);
    send_gap(32'h0000_0002);
    send_gap(32'h1111_1111);
    send_gap(32'h2222_2222);
    send_gap(32'hC000_0001);
    send_gap(32'h0000_005A);
    wait_done("t2");
    check("t2_words", {16'd0, words_written_o}, 32'd3);
    check("t2_busy", {31'd0, load_busy_o}, 32'd0);
    check("t2_qempty", exp_q.size(), 32'd0);
    gnt_wait = 0;

    // Stalled crossbar overflows the receive FIFO
    do_reset();
    stall = 1;
    send_gap(32'h0000_0008);
    send(32'hD0);
    wait_req("t3");
    send(32'hD1);
    send(32'hD2);
    send(32'hD3);
    repeat (100) @(negedge clk_i);
    check("t3_err", {31'd0, err_o}, 32'd1);
    check("t3_req", {31'd0, mem_req_o}, 32'd0);
    check("t3_rstn", {31'd0, system_rst_no}, 32'd0);
    en_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("t3_rstn_en", {31'd0, system_rst_no}, 32'd0);
    check("t3_words", {16'd0, words_written_o}, 32'd0);
    stall = 0;

    // Bad header
    do_reset();
    rc = req_cycles;
    send(32'h8001_0004);
    repeat (2) @(negedge clk_i);
    check("t4_err", {31'd0, err_o}, 32'd1);
    repeat (20) @(negedge clk_i);
    check("t4_no_req", req_cycles - rc, 32'd0);
    check("t4_done", {31'd0, load_done_o}, 32'd0);

    // Reset while a request is outstanding
    do_reset();
    stall = 1;
    send_gap(32'h0000_0004);
    send(32'h77);
    wait_req("t5");
    check("t5_req_high", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset("t5_midrst");
    rst_i = 1'b0;
    stall = 0;
    expect_wr(32'h0, 32'hAA);
    expect_wr(32'h4, 32'hBB);
    send_gap(32'h8000_0002);
    send_gap(32'hAA);
    send_gap(32'hBB);
    wait_done("t5");
    check("t5_words", {16'd0, words_written_o}, 32'd2);
    check("t5_qempty", exp_q.size(), 32'd0);

    // Coincident grant/response, early en_i, empty last header
    do_reset();
    coincide = 1;
    en_i = 1'b1;
    expect_wr(32'h1000_0000, 32'hC0DE);
    send_gap(32'h4000_0001);
    send_gap(32'hC0DE);
    wait_drain("t6");
    repeat (4) @(negedge clk_i);
    check("t6_early_en_rstn", {31'd0, system_rst_no}, 32'd0);
    check("t6_not_done", {31'd0, load_done_o}, 32'd0);
    check("t6_words1", {16'd0, words_written_o}, 32'd1);
    rc = req_cycles;
    send(32'h8000_0000);
    wait_done("t6");
    check("t6_rstn_in_done", {31'd0, system_rst_no}, 32'd0);
    @(negedge clk_i);
    check("t6_rstn_release", {31'd0, system_rst_no}, 32'd1);
    check("t6_no_write", req_cycles - rc, 32'd0);
    check("t6_words", {16'd0, words_written_o}, 32'd1);
    coincide = 0;

    check("final_qempty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
